// File: rtl/rib_timer_pkg.sv
// Shared tinyriscv constants: RIB handshake levels, interrupt ids,
// timer register offsets, CTRL bit indices and the slave FSM states.
package rib_timer_pkg;

   localparam logic RIB_ACK = 1'b1;
   localparam logic RIB_REQ = 1'b1;

   localparam logic [7:0] INT_TIMER0 = 8'b0000_0001;

   localparam logic [3:0] REG_CTRL  = 4'h0;
   localparam logic [3:0] REG_COUNT = 4'h4;
   localparam logic [3:0] REG_VALUE = 4'h8;

   localparam int CTRL_EN   = 0;
   localparam int CTRL_IE   = 1;
   localparam int CTRL_PEND = 2;

   typedef enum logic {
      RIB_IDLE,
      RIB_RESP
   } rib_state_e;

endpackage

// File: rtl/rib_slave_if.sv
// RIB slave front end: IDLE/RESP FSM, read-data capture, ack pulse.
// Ports: clk, rst, req_i, we_i, rdata (read mux), wr_en, ack_o, data_o.
module rib_slave_if
   import rib_timer_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] rdata,
   output logic        wr_en,
   output logic        ack_o,
   output logic [31:0] data_o
);

   rib_state_e  state_q;
   rib_state_e  state_d;
   logic [31:0] rdata_q;
   logic        accept;

   // A request is only taken in IDLE; req_i held in RESP is ignored.
   assign accept = (state_q == RIB_IDLE) && (req_i == RIB_REQ);
   assign wr_en  = accept && we_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RIB_IDLE;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            rdata_q <= rdata;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RIB_IDLE: begin
            if (accept) begin
               state_d = RIB_RESP;
            end
         end
         RIB_RESP: begin
            state_d = RIB_IDLE;
         end
         default: begin
            state_d = RIB_IDLE;
         end
      endcase
   end

   assign ack_o  = (state_q == RIB_RESP) ? RIB_ACK : ~RIB_ACK;
   assign data_o = (state_q == RIB_RESP) ? rdata_q : '0;

endmodule

// File: rtl/rib_timer.sv
// RIB-attached one-shot timer with prescaler and level interrupt.
// Ports: clk, rst, req_i, we_i, addr_i, data_i, data_o, ack_o, int_sig_o.
module rib_timer
   import rib_timer_pkg::*;
#(
   parameter int unsigned PRESCALE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        ack_o,
   output logic        int_sig_o
);

   localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

   logic        en_q;
   logic        ie_q;
   logic        pend_q;
   logic [31:0] count_q;
   logic [31:0] value_q;
   logic [15:0] presc_q;

   logic        wr_en;
   logic        wr_ctrl;
   logic        wr_value;
   logic [3:0]  reg_addr;
   logic [31:0] rdata;
   logic        tick;
   logic        expire;
   logic [32:0] count_inc;
   logic        unused_addr;

   assign reg_addr    = addr_i[3:0];
   assign unused_addr = ^addr_i[31:4];

   rib_slave_if u_slave (
      .clk    (clk),
      .rst    (rst),
      .req_i  (req_i),
      .we_i   (we_i),
      .rdata  (rdata),
      .wr_en  (wr_en),
      .ack_o  (ack_o),
      .data_o (data_o)
   );

   assign wr_ctrl  = wr_en && (reg_addr == REG_CTRL);
   assign wr_value = wr_en && (reg_addr == REG_VALUE);

   // 33-bit increment keeps the compare exact at COUNT = 0xFFFFFFFF.
   assign tick      = en_q && (presc_q == PRESC_MAX);
   assign count_inc = {1'b0, count_q} + 33'd1;
   assign expire    = tick && (count_inc >= {1'b0, value_q});

   always_ff @(posedge clk) begin
      if (rst) begin
         en_q    <= 1'b0;
         ie_q    <= 1'b0;
         pend_q  <= 1'b0;
         count_q <= '0;
         value_q <= '0;
         presc_q <= '0;
      end else begin
         if (!en_q || tick) begin
            presc_q <= '0;
         end else begin
            presc_q <= presc_q + 16'd1;
         end

         if (expire) begin
            count_q <= '0;
         end else if (tick) begin
            count_q <= count_inc[31:0];
         end

         // Expiry overrides a same-cycle CTRL write for EN and PEND.
         if (expire) begin
            en_q <= 1'b0;
         end else if (wr_ctrl) begin
            en_q <= data_i[CTRL_EN];
         end

         if (wr_ctrl) begin
            ie_q <= data_i[CTRL_IE];
         end

         if (expire) begin
            pend_q <= 1'b1;
         end else if (wr_ctrl && data_i[CTRL_PEND]) begin
            pend_q <= 1'b0;
         end

         if (wr_value) begin
            value_q <= data_i;
         end
      end
   end

   always_comb begin
      rdata = '0;
      unique case (1'b1)
         (reg_addr == REG_CTRL):  rdata = {29'b0, pend_q, ie_q, en_q};
         (reg_addr == REG_COUNT): rdata = count_q;
         (reg_addr == REG_VALUE): rdata = value_q;
         default:                 rdata = '0;
      endcase
   end

   assign int_sig_o = pend_q & ie_q;

endmodule

// File: tb/tb_rib_timer.sv
// Directed bench for rib_timer: PRESCALE=1 and PRESCALE=4 instances
// share one bus stimulus; outputs are checked per instance.
module tb_rib_timer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] data1, data4;
   logic        ack1, ack4, int1, int4;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   rib_timer #(.PRESCALE(1)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .req_i     (req),
      .we_i      (we),
      .addr_i    (addr),
      .data_i    (wdata),
      .data_o    (data1),
      .ack_o     (ack1),
      .int_sig_o (int1)
   );

   rib_timer #(.PRESCALE(4)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .req_i     (req),
      .we_i      (we),
      .addr_i    (addr),
      .data_i    (wdata),
      .data_o    (data4),
      .ack_o     (ack4),
      .int_sig_o (int4)
   );

   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[13];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic access(input string name, input logic w,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] r1, output logic [31:0] r4);
      req = 1'b1;
      we = w;
      addr = a;
      wdata = d;
      chk({name, " pre-ack"}, 32'(ack1), 0);
      step();
      chk({name, " ack"}, 32'(ack1), 1);
      chk({name, " ack4"}, 32'(ack4), 1);
      r1 = data1;
      r4 = data4;
      req = 1'b0;
      we = 1'b0;
      step();
      chk({name, " ack drop"}, 32'(ack1), 0);
   endtask

   task automatic reset_all();
      rst = 1'b1;
      req = 1'b0;
      we = 1'b0;
      step();
      step();
      rst = 1'b0;
      chk("rst ack", 32'(ack1), 0);
      chk("rst data", data1, 0);
      chk("rst int", 32'(int1), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] r1, r4;

      tbl[0]  = '{1'b0, 32'h0,  32'h0,        32'h0};
      tbl[1]  = '{1'b0, 32'h4,  32'h0,        32'h0};
      tbl[2]  = '{1'b0, 32'h8,  32'h0,        32'h0};
      tbl[3]  = '{1'b1, 32'hC,  32'hDEADBEEF, 32'h0};
      tbl[4]  = '{1'b0, 32'hC,  32'h0,        32'h0};
      tbl[5]  = '{1'b1, 32'h8,  32'h1234,     32'h0};
      tbl[6]  = '{1'b0, 32'h8,  32'h0,        32'h1234};
      tbl[7]  = '{1'b0, 32'h18, 32'h0,        32'h1234};
      tbl[8]  = '{1'b1, 32'h4,  32'h55,       32'h0};
      tbl[9]  = '{1'b0, 32'h4,  32'h0,        32'h0};
      tbl[10] = '{1'b1, 32'h0,  32'hFFFFFFFA, 32'h0};
      tbl[11] = '{1'b0, 32'h0,  32'h0,        32'h2};
      tbl[12] = '{1'b0, 32'h10, 32'h0,        32'h2};

      reset_all();

      foreach (tbl[i]) begin
         access($sformatf("vec%0d", i), tbl[i].w, tbl[i].a, tbl[i].d, r1, r4);
         if (!tbl[i].w) begin
            chk($sformatf("vec%0d rd1", i), r1, tbl[i].exp);
            chk($sformatf("vec%0d rd4", i), r4, tbl[i].exp);
         end
      end

      // Expiry with PRESCALE=1, VALUE=5
      reset_all();
      access("wr value5", 1'b1, 32'h8, 32'd5, r1, r4);
      access("wr ctrl3", 1'b1, 32'h0, 32'h3, r1, r4);
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("int1 low cyc%0d", k), 32'(int1), 0);
         step();
      end
      chk("int1 rise cyc5", 32'(int1), 1);
      access("rd ctrl", 1'b0, 32'h0, 32'h0, r1, r4);
      chk("ctrl after expiry", r1, 32'h6);
      access("rd count", 1'b0, 32'h4, 32'h0, r1, r4);
      chk("count after expiry", r1, 32'h0);

      // PEND clear, int falls right after commit
      req = 1'b1;
      we = 1'b1;
      addr = 32'h0;
      wdata = 32'h6;
      step();
      chk("clr ack", 32'(ack1), 1);
      chk("int1 fall", 32'(int1), 0);
      req = 1'b0;
      we = 1'b0;
      step();
      access("rd ctrl clr", 1'b0, 32'h0, 32'h0, r1, r4);
      chk("ctrl after clr", r1, 32'h2);

      // Clear of PEND on the expiry cycle loses
      access("wr ctrl3b", 1'b1, 32'h0, 32'h3, r1, r4);
      step();
      step();
      step();
      access("wr ctrl7 coll", 1'b1, 32'h0, 32'h7, r1, r4);
      access("rd ctrl coll", 1'b0, 32'h0, 32'h0, r1, r4);
      chk("ctrl collision", r1, 32'h6);
      chk("int1 collision", 32'(int1), 1);

      // VALUE = 0 expires on the first tick
      access("wr value0", 1'b1, 32'h8, 32'h0, r1, r4);
      access("wr ctrl7 v0", 1'b1, 32'h0, 32'h7, r1, r4);
      chk("int1 value0", 32'(int1), 1);
      access("rd ctrl v0", 1'b0, 32'h0, 32'h0, r1, r4);
      chk("ctrl value0", r1, 32'h6);

      // PRESCALE=4, VALUE=3
      reset_all();
      access("wr value3", 1'b1, 32'h8, 32'd3, r1, r4);
      access("wr ctrl3 p4", 1'b1, 32'h0, 32'h3, r1, r4);
      step();
      step();
      step();
      access("rd count1", 1'b0, 32'h4, 32'h0, r1, r4);
      chk("p4 count 1", r4, 32'd1);
      step();
      step();
      access("rd count2", 1'b0, 32'h4, 32'h0, r1, r4);
      chk("p4 count 2", r4, 32'd2);
      chk("int4 cyc10", 32'(int4), 0);
      step();
      chk("int4 cyc11", 32'(int4), 0);
      step();
      chk("int4 cyc12", 32'(int4), 1);
      access("rd ctrl p4", 1'b0, 32'h0, 32'h0, r1, r4);
      chk("p4 ctrl", r4, 32'h6);

      // Reset while acking
      req = 1'b1;
      we = 1'b0;
      addr = 32'h0;
      step();
      chk("mid ack", 32'(ack4), 1);
      rst = 1'b1;
      step();
      chk("rst kills ack", 32'(ack4), 0);
      chk("rst kills data", data4, 0);
      rst = 1'b0;
      req = 1'b0;
      step();
      chk("int4 after rst", 32'(int4), 0);
      access("rd ctrl r", 1'b0, 32'h0, 32'h0, r1, r4);
      chk("ctrl after rst", r4, 32'h0);
      access("rd count r", 1'b0, 32'h4, 32'h0, r1, r4);
      chk("count after rst", r4, 32'h0);
      access("rd value r", 1'b0, 32'h8, 32'h0, r1, r4);
      chk("value after rst", r4, 32'h0);
      access("wr 0xC", 1'b1, 32'hC, 32'h12345678, r1, r4);
      access("rd 0xC", 1'b0, 32'hC, 32'h0, r1, r4);
      chk("rd 0xC data", r4, 32'h0);

      // Write in the reset cycle is dropped
      access("wr value7", 1'b1, 32'h8, 32'd7, r1, r4);
      rst = 1'b1;
      req = 1'b1;
      we = 1'b1;
      addr = 32'h8;
      wdata = 32'd9;
      step();
      chk("rst+wr no ack", 32'(ack1), 0);
      rst = 1'b0;
      req = 1'b0;
      we = 1'b0;
      step();
      access("rd value rw", 1'b0, 32'h8, 32'h0, r1, r4);
      chk("value rst+wr", r1, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
